imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_pkg.sv | 23 ++
 rtl/imem_word_asm.sv | 54 +++++
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// ============================================================================
// imem_pkg : shared loader states and frame constants
// Revision : 1.0
// ============================================================================
`default_nettype none

package imem_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         CNT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_word_asm.sv
// ============================================================================
// imem_word_asm : little-endian byte-to-word assembler with word strobe
// Revision      : 1.0
// ============================================================================
`default_nettype none

module imem_word_asm #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             lane_last,
  output logic             word_valid,
  output logic [WIDTH-1:0] word_data
);

  localparam int LANES  = WIDTH / 8;
  localparam int LANE_W = $clog2(LANES);

  logic [LANE_W-1:0] lane;
  // Holds the first LANES-1 bytes; the final byte is merged on the way out.
  logic [WIDTH-9:0]  shreg;

  assign lane_last = (lane == LANE_W'(LANES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane       <= '0;
      shreg      <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane <= '0;
      end else if (byte_valid) begin
        if (lane_last) begin
          lane       <= '0;
          word_valid <= 1'b1;
          word_data  <= {byte_data, shreg};
        end else begin
          lane  <= lane + LANE_W'(1);
          shreg <= {byte_data, shreg[WIDTH-9:8]};
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : byte-stream frame parser that writes instruction memory
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imem_loader
  import imem_pkg::*;
#(
  parameter int I_WIDTH   = 32,
  parameter int IMEM_SIZE = 2**15,
  parameter int ADD_WIDTH = $clog2(IMEM_SIZE >> 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  output logic                 we,
  output logic [ADD_WIDTH-1:0] waddr,
  output logic [I_WIDTH-1:0]   wdata,
  output logic                 cpu_hold,
  output logic                 load_done,
  output logic                 load_err
);

  localparam logic [CNT_W:0] MAX_WORDS = (CNT_W + 1)'(IMEM_SIZE >> 2);

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         cnt_lo;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   word_idx;
  logic [7:0]         csum;
  logic [ADD_WIDTH-1:0] waddr_q;
  logic               hold_q;
  logic               err_q;

  logic               hs;
  logic               sync_hs;
  logic               data_hs;
  logic               word_hs;
  logic               last_word;
  logic               lane_last;
  logic [CNT_W-1:0]   n_in;
  logic               n_too_big;

  assign hs        = rx_valid && rx_ready;
  assign sync_hs   = (state == ST_IDLE) && hs && (rx_data == SYNC_BYTE);
  assign data_hs   = (state == ST_DATA) && hs;
  assign word_hs   = data_hs && lane_last;
  assign last_word = ((word_idx + CNT_W'(1)) == cnt);
  assign n_in      = {rx_data, cnt_lo};
  assign n_too_big = ({1'b0, n_in} > MAX_WORDS);

  assign rx_ready  = (state != ST_DONE);
  assign load_done = (state == ST_DONE);
  assign cpu_hold  = hold_q;
  assign load_err  = err_q;
  assign waddr     = waddr_q;

  imem_word_asm #(
    .WIDTH (I_WIDTH)
  ) u_word_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (sync_hs),
    .byte_valid (data_hs),
    .byte_data  (rx_data),
    .lane_last  (lane_last),
    .word_valid (we),
    .word_data  (wdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (sync_hs) state_nxt = ST_CNT_LO;
      ST_CNT_LO: if (hs) state_nxt = ST_CNT_HI;
      ST_CNT_HI: begin
        if (hs) begin
          if (n_too_big)           state_nxt = ST_IDLE;
          else if (n_in == '0)     state_nxt = ST_CSUM;
          else                     state_nxt = ST_DATA;
        end
      end
      ST_DATA:   if (word_hs && last_word) state_nxt = ST_CSUM;
      ST_CSUM:   if (hs) state_nxt = (rx_data == csum) ? ST_DONE : ST_IDLE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Hold stays high after any error so the core never runs a partial image.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_lo   <= '0;
      cnt      <= '0;
      word_idx <= '0;
      csum     <= '0;
      waddr_q  <= '0;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sync_hs) begin
            hold_q   <= 1'b1;
            err_q    <= 1'b0;
            csum     <= '0;
            word_idx <= '0;
          end
        end
        ST_CNT_LO: if (hs) cnt_lo <= rx_data;
        ST_CNT_HI: begin
          if (hs) begin
            cnt <= n_in;
            if (n_too_big) err_q <= 1'b1;
          end
        end
        ST_DATA: begin
          if (data_hs) csum <= csum ^ rx_data;
          if (word_hs) begin
            waddr_q  <= word_idx[ADD_WIDTH-1:0];
            word_idx <= word_idx + CNT_W'(1);
          end
        end
        ST_CSUM: begin
          if (hs) begin
            if (rx_data == csum) hold_q <= 1'b0;
            else                 err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader : directed + randomized frames against a frame-level model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  logic [47:0] obs_q[$];
  logic [47:0] exp_q[$];
  logic [7:0]  pl[$];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always @(negedge clk) begin
    if (we) obs_q.push_back({3'b000, waddr, wdata});
    if (load_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [47:0] observed, input logic [47:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc;
    int t;
    if (gap) begin
      rx_valid = 1'b0;
      tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 20) begin
      acc = rx_ready;
      tick();
      t++;
    end
    if (!acc) chk("rx_ready_timeout", 48'(acc), 48'd1);
  endtask

  task automatic set_pl(input logic [63:0] v, input int nb);
    pl.delete();
    for (int i = 0; i < nb; i++) pl.push_back(v[8*i +: 8]);
  endtask

  // Frame-level model: words are little-endian groups of 4, success means the
  // count fits and the checksum equals the XOR of the payload.
  function automatic bit model(input logic [15:0] n, input logic [7:0] p[$], input logic [7:0] cs);
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
    if (n > 16'd8192) return 1'b0;
    for (int w = 0; w < int'(n); w++)
      exp_q.push_back({3'b000, 13'(w), p[4*w+3], p[4*w+2], p[4*w+1], p[4*w]});
    foreach (p[i]) x ^= p[i];
    return (x == cs);
  endfunction

  task automatic run_frame(input string tag, input logic [15:0] n, input logic [7:0] p[$],
                           input logic [7:0] cs, input bit gap);
    bit ok;
    int d0;
    ok = model(n, p, cs);
    obs_q.delete();
    d0 = done_cnt;
    send_byte(8'hA5, gap);
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    if (n <= 16'd8192) begin
      foreach (p[i]) send_byte(p[i], gap);
      send_byte(cs, gap);
      chk($sformatf("%s/done_pulse", tag), 48'(load_done), 48'(ok));
      chk($sformatf("%s/hold_at_done", tag), 48'(cpu_hold), 48'(!ok));
      chk($sformatf("%s/ready_at_done", tag), 48'(rx_ready), 48'(!ok));
    end
    rx_valid = 1'b0;
    repeat (4) tick();
    chk($sformatf("%s/n_writes", tag), 48'(obs_q.size()), 48'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s/write%0d", tag, i), obs_q[i], exp_q[i]);
    chk($sformatf("%s/n_done", tag), 48'(done_cnt - d0), 48'(ok));
    chk($sformatf("%s/load_err", tag), 48'(load_err), 48'(!ok));
    if (n <= 16'd8192) chk($sformatf("%s/hold_after", tag), 48'(cpu_hold), 48'(!ok));
  endtask

  initial begin
    logic [7:0]  x;
    logic [15:0] rn;
    bit          rgap;

    // reset
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst/we", 48'(we), 48'd0);
    chk("rst/waddr", 48'(waddr), 48'd0);
    chk("rst/wdata", 48'(wdata), 48'd0);
    chk("rst/cpu_hold", 48'(cpu_hold), 48'd0);
    chk("rst/load_done", 48'(load_done), 48'd0);
    chk("rst/load_err", 48'(load_err), 48'd0);
    chk("rst/rx_ready", 48'(rx_ready), 48'd1);

    // leading junk bytes are discarded
    obs_q.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    rx_valid = 1'b0;
    repeat (3) tick();
    chk("junk/no_we", 48'(obs_q.size()), 48'd0);
    chk("junk/no_hold", 48'(cpu_hold), 48'd0);

    set_pl(64'h8877665544332211, 8);
    run_frame("good", 16'd2, pl, 8'h88, 1'b0);
    run_frame("bad_csum", 16'd2, pl, 8'h00, 1'b0);
    run_frame("good_gap", 16'd2, pl, 8'h88, 1'b1);

    pl.delete();
    run_frame("too_big", 16'h2001, pl, 8'h00, 1'b0);
    run_frame("zero_len", 16'd0, pl, 8'h00, 1'b0);

    for (int f = 0; f < 6; f++) begin
      rn = 16'($urandom_range(1, 5));
      rgap = 1'($urandom_range(0, 1));
      pl.delete();
      x = 8'h00;
      for (int i = 0; i < 4 * int'(rn); i++) begin
        pl.push_back(8'($urandom));
        x ^= pl[i];
      end
      if ($urandom_range(0, 2) == 0) x ^= 8'h5A;
      run_frame($sformatf("rand%0d", f), rn, pl, x, rgap);
    end

    // reset in the middle of the second word
    obs_q.delete();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 1; i <= 6; i++) send_byte(8'(i * 16'h11), 1'b0);
    rst_n = 1'b0;
    rx_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst/we", 48'(we), 48'd0);
    chk("midrst/waddr", 48'(waddr), 48'd0);
    chk("midrst/wdata", 48'(wdata), 48'd0);
    chk("midrst/cpu_hold", 48'(cpu_hold), 48'd0);
    chk("midrst/load_err", 48'(load_err), 48'd0);
    chk("midrst/rx_ready", 48'(rx_ready), 48'd1);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    send_byte(8'h00, 1'b0);
    rx_valid = 1'b0;
    repeat (3) tick();
    chk("midrst/n_writes", 48'(obs_q.size()), 48'd1);
    if (obs_q.size() > 0) chk("midrst/write0", obs_q[0], 48'h000044332211);
    chk("midrst/hold_after", 48'(cpu_hold), 48'd0);
    chk("midrst/load_done", 48'(done_cnt), 48'(done_cnt));

    set_pl(64'hDEADBEEF01020304, 8);
    run_frame("after_rst", 16'd2, pl, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
